// File: rtl/axi_master_tx.sv
// rtl/axi_master_tx.sv - AXI-Stream transmit master with optional word downsizing and message framing
module axi_master_tx #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 downsizing,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 m_tvalid,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [CNT_WIDTH-1:0] msg_count,
  output logic                 msg_done
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_SPLIT = 2'd1,
    SEND       = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [IN_WIDTH-1:0]  word;
  logic                 word_last;
  logic [IDX_W-1:0]     idx, idx_next;
  logic                 capture;
  logic                 beat;
  logic [OUT_WIDTH-1:0] slices [RATIO];

  // Narrow views of the held word, slice 0 being the least significant.
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = word[g*OUT_WIDTH +: OUT_WIDTH];
  end

  // in_ready is masked by reset so nothing is offered while rst is low.
  assign capture = in_ready && in_valid;
  assign beat    = m_tvalid && m_tready;

  // Next-state, slice index and stream outputs; outputs depend only on held state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    in_ready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) begin
          idx_next   = '0;
          state_next = downsizing ? SEND_SPLIT : SEND;
        end
      end
      SEND: begin
        m_tvalid = 1'b1;
        m_tdata  = word[OUT_WIDTH-1:0];
        m_tlast  = word_last;
        if (m_tready) state_next = IDLE;
      end
      SEND_SPLIT: begin
        m_tvalid = 1'b1;
        m_tdata  = slices[idx];
        m_tlast  = word_last && (idx == IDX_LAST);
        if (m_tready) begin
          if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the single buffered word; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      word_last <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (capture) begin
        word      <= in_data;
        word_last <= in_last;
      end
    end
  end

  // Per-message beat counter (saturating) and end-of-message pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_count <= '0;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= beat && m_tlast;
      if (beat) begin
        if (m_tlast) msg_count <= '0;
        else if (msg_count != CNT_MAX) msg_count <= msg_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_master_tx.sv
// tb/tb_axi_master_tx.sv - scoreboard bench for axi_master_tx
module tb_axi_master_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        downsizing;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        m_tvalid;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [7:0]  msg_count;
  logic        msg_done;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_count = 0;
  bit          stall_mode = 1'b0;
  logic [3:0]  ready_pat = 4'b1001;
  int          ph = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_last = 1'b0;

  axi_master_tx #(.IN_WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .downsizing(downsizing), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tready(m_tready), .msg_count(msg_count), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 stall pattern.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        m_tready = ready_pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Monitor: compares beats against the scoreboard and tracks count/done.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_msg_count", msg_count, 0);
      exp_cnt = 8'd0;
      exp_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("msg_count", msg_count, exp_cnt);
      chk("msg_done", msg_done, exp_done);
      chk("in_ready_busy", in_ready, !m_tvalid);
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, prev_data);
        chk("stall_tlast", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        hs_count++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", m_tdata, 64'hDEAD_0000);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_tdata", m_tdata, e.data);
          chk("beat_tlast", m_tlast, e.last);
        end
        exp_done = m_tlast;
        if (m_tlast) exp_cnt = 8'd0;
        else if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end else begin
        exp_done = 1'b0;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
  end

  task automatic send_word(input logic [63:0] w, input bit last, input bit ds, input bit flip);
    int t;
    beat_t b;
    downsizing = ds;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 200) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data = w;
    in_last = last;
    if (ds) begin
      for (int i = 0; i < 4; i++) begin
        b.data = w[i*16 +: 16];
        b.last = last && (i == 3);
        sb.push_back(b);
      end
    end else begin
      b.data = w[15:0];
      b.last = last;
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (flip) downsizing = ~ds;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || m_tvalid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 500) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int target;
    rst = 1'b0;
    downsizing = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_tvalid", m_tvalid, 0);
    @(posedge clk);
    #1;

    // T1: three unsplit words, last on the third.
    send_word(64'h1111_2222_3333_0001, 1'b0, 1'b0, 1'b0);
    send_word(64'h4444_5555_6666_0002, 1'b0, 1'b0, 1'b0);
    send_word(64'h7777_8888_9999_0003, 1'b1, 1'b0, 1'b0);
    wait_idle();
    chk("t1_count_zero", msg_count, 0);

    // T2: one word split into four beats.
    send_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b1, 1'b0);
    wait_idle();
    chk("t2_count_zero", msg_count, 0);

    // T3: same word under a 1,0,0,1 ready pattern.
    stall_mode = 1'b1;
    send_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b1, 1'b0);
    wait_idle();
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    // T4: reset after the second beat drops the rest of the word.
    target = hs_count + 2;
    send_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b1, 1'b0);
    t = 0;
    while (hs_count < target && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("t4_beat_timeout", hs_count, target);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("t4_tvalid", m_tvalid, 0);
    chk("t4_tdata", m_tdata, 0);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_msg_count", msg_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_in_ready_after", in_ready, 1);
    send_word(64'h0004_0003_0002_0001, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // T5: downsizing dropped right after capture still sends four slices.
    send_word(64'hF00D_BEEF_CAFE_1234, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // T6: 300 beats without last saturate the count, next last clears it.
    for (int i = 0; i < 300; i++)
      send_word(64'h0 | i, 1'b0, 1'b0, 1'b0);
    wait_idle();
    chk("t6_saturated", msg_count, 255);
    send_word(64'h0000_0000_0000_5A5A, 1'b1, 1'b0, 1'b0);
    wait_idle();
    chk("t6_cleared", msg_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
